// File: rtl/afd_sad.sv
// Two-lane absolute-difference accumulator for block matching.
// Stage 1 forms |a0-b0|+|a1-b1|; stage 2 loads or accumulates it.
module afd_sad #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               acum,
  input  logic [WIDTH-1:0]   a0,
  input  logic [WIDTH-1:0]   a1,
  input  logic [WIDTH-1:0]   b0,
  input  logic [WIDTH-1:0]   b1,
  output logic [WIDTH+7:0]   out_afd
);

  logic [WIDTH-1:0] w_d0;
  logic [WIDTH-1:0] w_d1;
  logic [WIDTH:0]   w_s1;

  logic [WIDTH:0]   r_s1;
  logic             r_en_d;
  logic             r_acum_d;
  logic [WIDTH+7:0] r_acc;

  // Compare-and-subtract keeps each difference unsigned.
  always_comb begin
    w_d0 = (a0 >= b0) ? (a0 - b0) : (b0 - a0);
    w_d1 = (a1 >= b1) ? (a1 - b1) : (b1 - a1);
    w_s1 = {1'b0, w_d0} + {1'b0, w_d1};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1     <= '0;
      r_en_d   <= 1'b0;
      r_acum_d <= 1'b0;
    end else begin
      r_s1     <= w_s1;
      r_en_d   <= en;
      r_acum_d <= acum;
    end
  end

  // Accumulator wraps modulo 2^(WIDTH+8).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_acc <= '0;
    end else if (r_en_d) begin
      if (r_acum_d)
        r_acc <= r_acc + {7'd0, r_s1};
      else
        r_acc <= {7'd0, r_s1};
    end
  end

  assign out_afd = r_acc;

endmodule

// File: tb/tb_afd_sad.sv
// Self-checking bench for afd_sad: vector table, corner
// sequences and a randomized run against an arithmetic model.
module tb_afd_sad;

  localparam int W = 8;

  logic           clk;
  logic           rst;
  logic           en;
  logic           acum;
  logic [W-1:0]   a0;
  logic [W-1:0]   a1;
  logic [W-1:0]   b0;
  logic [W-1:0]   b1;
  logic [W+7:0]   out_afd;

  int checks;
  int errors;
  int model;

  afd_sad #(.WIDTH(W)) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .acum(acum),
    .a0(a0),
    .a1(a1),
    .b0(b0),
    .b1(b1),
    .out_afd(out_afd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int a0;
    int b0;
    int a1;
    int b1;
    bit acum;
    int exp;
  } vec_t;

  vec_t tbl[6];

  function automatic int absdiff(input int x, input int y);
    return (x > y) ? x - y : y - x;
  endfunction

  // Reference: a partition's cost is the wrapped sum of its terms.
  function automatic int apply(input int acc, input bit ac,
                               input int x0, input int y0,
                               input int x1, input int y1);
    int t;
    t = absdiff(x0, y0) + absdiff(x1, y1);
    return ac ? (acc + t) % 65536 : t;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic drive(input bit e, input bit ac,
                       input int x0, input int y0,
                       input int x1, input int y1);
    en   = e;
    acum = ac;
    a0   = W'(x0);
    b0   = W'(y0);
    a1   = W'(x1);
    b1   = W'(y1);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 0, 0, 0, 0);
  endtask

  initial begin
    int x0, y0, x1, y1, n;
    bit ac;
    checks = 0;
    errors = 0;
    model  = 0;

    tbl[0] = '{10, 3, 2, 9, 1'b0, 14};
    tbl[1] = '{255, 0, 0, 255, 1'b0, 510};
    tbl[2] = '{5, 1, 1, 5, 1'b1, 518};
    tbl[3] = '{0, 0, 0, 0, 1'b0, 0};
    tbl[4] = '{0, 200, 77, 7, 1'b1, 270};
    tbl[5] = '{3, 3, 9, 9, 1'b1, 270};

    // Reset held with live inputs
    rst = 1'b0;
    en = 1'b1; acum = 1'b1;
    a0 = 8'd200; b0 = 8'd1; a1 = 8'd50; b1 = 8'd90;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_hold", int'(out_afd), 0);
    en = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("post_reset_idle", int'(out_afd), 0);
      idle();
    end

    // Table vectors, each followed by one draining edge
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, tbl[i].acum, tbl[i].a0, tbl[i].b0,
            tbl[i].a1, tbl[i].b1);
      idle();
      chk($sformatf("table_%0d", i), int'(out_afd), tbl[i].exp);
    end

    // Single load then hold over idle cycles
    drive(1'b1, 1'b0, 10, 3, 2, 9);
    idle();
    for (int i = 0; i < 5; i++) begin
      chk("load_hold", int'(out_afd), 14);
      idle();
    end

    // acum with en=0 is ignored
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, 90, 10, 4, 200);
      chk("ignore_acum", int'(out_afd), 14);
    end
    idle();
    chk("ignore_acum_end", int'(out_afd), 14);

    // Wrap: 129 terms of 510
    drive(1'b1, 1'b0, 255, 0, 0, 255);
    for (int i = 0; i < 128; i++)
      drive(1'b1, 1'b1, 255, 0, 0, 255);
    idle();
    chk("wrap", int'(out_afd), 254);

    // Back-to-back partitions with no bubble
    drive(1'b1, 1'b0, 20, 10, 0, 0);
    drive(1'b1, 1'b1, 0, 5, 0, 0);
    drive(1'b1, 1'b0, 1, 2, 3, 4);
    idle();
    chk("back_to_back", int'(out_afd), 2);

    // Asynchronous reset mid-partition
    drive(1'b1, 1'b0, 100, 0, 0, 0);
    drive(1'b1, 1'b1, 50, 0, 0, 0);
    #2;
    rst = 1'b0;
    #1;
    chk("async_reset", int'(out_afd), 0);
    en = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("reset_release", int'(out_afd), 0);
    drive(1'b1, 1'b0, 7, 2, 2, 7);
    idle();
    chk("load_after_reset", int'(out_afd), 10);

    // Random single-pair partitions
    for (int i = 0; i < 100; i++) begin
      x0 = $urandom_range(0, 255);
      y0 = $urandom_range(0, 255);
      x1 = $urandom_range(0, 255);
      y1 = $urandom_range(0, 255);
      drive(1'b1, 1'b0, x0, y0, x1, y1);
      idle();
      chk("rand_single", int'(out_afd),
          absdiff(x0, y0) + absdiff(x1, y1));
    end

    // Random multi-pair partitions with idle gaps
    model = int'(out_afd);
    for (int p = 0; p < 30; p++) begin
      n = $urandom_range(1, 12);
      for (int k = 0; k < n; k++) begin
        x0 = $urandom_range(0, 255);
        y0 = $urandom_range(0, 255);
        x1 = $urandom_range(0, 255);
        y1 = $urandom_range(0, 255);
        if ($urandom_range(0, 3) == 0) begin
          drive(1'b0, 1'($urandom_range(0, 1)), x0, y0, x1, y1);
        end else begin
          ac = (k != 0);
          model = apply(model, ac, x0, y0, x1, y1);
          drive(1'b1, ac, x0, y0, x1, y1);
        end
      end
      idle();
      chk("rand_partition", int'(out_afd), model);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
